// File: rtl/punch_resolver_if.sv
// -----------------------------------------------------------------------------
// punch_resolver_if
//   Bundles the punch inputs, the opponent defensive state and the resolver
//   results into one port.
//   master : driver of the punch/defence inputs (player input path, bench)
//   slave  : the punch_resolver itself
//   Signals:
//     punch_light, punch_heavy : synchronised key levels
//     can_be_hit               : 0 while the opponent is blocking
//     health[3:0]              : opponent health
//     hit, blocked             : one-cycle resolution pulses
//     flash                    : hit-flash strobe for the draw path
//     busy                     : punch cooldown active
//     ko                       : sticky, health reached 0
// -----------------------------------------------------------------------------
interface punch_resolver_if;
    logic       punch_light;
    logic       punch_heavy;
    logic       can_be_hit;
    logic [3:0] health;
    logic       hit;
    logic       blocked;
    logic       flash;
    logic       busy;
    logic       ko;

    modport master (
        output punch_light, punch_heavy, can_be_hit,
        input  health, hit, blocked, flash, busy, ko
    );

    modport slave (
        input  punch_light, punch_heavy, can_be_hit,
        output health, hit, blocked, flash, busy, ko
    );
endinterface

// File: rtl/punch_resolver.sv
// -----------------------------------------------------------------------------
// punch_resolver
//   Resolves player punches against the opponent's defensive state and owns
//   the opponent health register. A key press is reduced to a single rising
//   edge; an accepted punch either lands (damage, hit pulse, flash) or is
//   blocked (blocked pulse), then starts a cooldown during which further
//   punches are dropped. Reaching health 0 enters an absorbing KO state.
//   Ports:
//     clock    : system clock
//     reset_n  : synchronous, active-low reset
//     bus      : punch_resolver_if.slave (inputs punch_light, punch_heavy,
//                can_be_hit; outputs health, hit, blocked, flash, busy, ko)
//   All outputs come straight from flops; results of inputs sampled at one
//   edge are visible right after that edge.
// -----------------------------------------------------------------------------
module punch_resolver #(
    parameter logic [3:0] MAX_HEALTH   = 4'd10,
    parameter logic [3:0] LIGHT_DMG    = 4'd1,
    parameter logic [3:0] HEAVY_DMG    = 4'd3,
    parameter int         LIGHT_CD     = 8,
    parameter int         HEAVY_CD     = 20,
    parameter int         FLASH_CYCLES = 6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    punch_resolver_if.slave         bus
);

    localparam int CD_MAX = (LIGHT_CD > HEAVY_CD) ? LIGHT_CD : HEAVY_CD;
    localparam int CD_W   = $clog2(CD_MAX + 1);
    localparam int FL_W   = $clog2(FLASH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COOLDOWN = 2'd1,
        KO       = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [3:0]      health_q,  health_d;
    logic [CD_W-1:0] cd_q,      cd_d;
    logic [FL_W-1:0] fl_q,      fl_d;
    logic            lq_q,      hq_q;
    logic            hit_q,     hit_d;
    logic            blocked_q, blocked_d;
    logic            flash_q;
    logic            busy_q;
    logic            ko_q,      ko_d;

    logic            l_edge, h_edge, punch_go;
    logic [3:0]      dmg;
    logic [3:0]      new_health;
    logic [CD_W-1:0] cd_load;

    // A held key yields one edge; the previous-value flops run in every state
    // so a key pressed during cooldown cannot fire later on release of it.
    assign l_edge   = bus.punch_light & ~lq_q;
    assign h_edge   = bus.punch_heavy & ~hq_q;
    assign punch_go = l_edge | h_edge;

    // Simultaneous edges resolve as heavy.
    assign dmg        = h_edge ? HEAVY_DMG : LIGHT_DMG;
    assign cd_load    = h_edge ? CD_W'(HEAVY_CD) : CD_W'(LIGHT_CD);
    assign new_health = (health_q > dmg) ? (health_q - dmg) : 4'd0;

    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        cd_d      = cd_q;
        ko_d      = ko_q;
        hit_d     = 1'b0;
        blocked_d = 1'b0;
        // Flash runs down in every state, KO included.
        fl_d      = (fl_q != '0) ? (fl_q - FL_W'(1)) : '0;

        case (state_q)
            IDLE: begin
                if (punch_go) begin
                    cd_d = cd_load;
                    if (bus.can_be_hit) begin
                        health_d = new_health;
                        hit_d    = 1'b1;
                        fl_d     = FL_W'(FLASH_CYCLES);
                    end else begin
                        blocked_d = 1'b1;
                    end
                    if (bus.can_be_hit && (new_health == 4'd0)) begin
                        state_d = KO;
                        ko_d    = 1'b1;
                        cd_d    = '0;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                // Loaded with N at the accepting edge, so the state is left
                // on the N-th following edge: busy spans exactly N cycles.
                if (cd_q <= CD_W'(1)) begin
                    state_d = IDLE;
                    cd_d    = '0;
                end else begin
                    cd_d = cd_q - CD_W'(1);
                end
            end
            KO: begin
                health_d = 4'd0;
                ko_d     = 1'b1;
                cd_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            health_q  <= MAX_HEALTH;
            cd_q      <= '0;
            fl_q      <= '0;
            lq_q      <= 1'b0;
            hq_q      <= 1'b0;
            hit_q     <= 1'b0;
            blocked_q <= 1'b0;
            flash_q   <= 1'b0;
            busy_q    <= 1'b0;
            ko_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            health_q  <= health_d;
            cd_q      <= cd_d;
            fl_q      <= fl_d;
            lq_q      <= bus.punch_light;
            hq_q      <= bus.punch_heavy;
            hit_q     <= hit_d;
            blocked_q <= blocked_d;
            flash_q   <= (fl_d != '0);
            busy_q    <= (state_d == COOLDOWN);
            ko_q      <= ko_d;
        end
    end

    assign bus.health  = health_q;
    assign bus.hit     = hit_q;
    assign bus.blocked = blocked_q;
    assign bus.flash   = flash_q;
    assign bus.busy    = busy_q;
    assign bus.ko      = ko_q;

endmodule
